// File: rtl/fault_sched_pkg.sv
// Shared types and sizing constants for the fault trigger scheduler.
// Pure declarations: no logic, no latency.
package fault_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_FIRE = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

    // Wide enough for the 1..15 gap-length range.
    localparam int GAP_CNT_W = 4;

    // Headroom bits above the pending width so a saturating add can see its own carry.
    localparam int SAT_EXTRA_W = 1;

endpackage

// File: rtl/trig_popcount.sv
// Combinational population count of the trigger vector.
// Zero latency; no flow control.
module trig_popcount #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_in,
    output logic [CNT_W-1:0] count_out
);

    always_comb begin
        count_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_out = count_out + CNT_W'(bits_in[i]);
        end
    end

endmodule

// File: rtl/fault_trigger_scheduler.sv
// Queues trigger pulses and issues them as spaced single-cycle fault pulses with a lamp snapshot.
// Trigger to fault_out: 2 edges after the pending increment; one pulse per 2+GAP_CYCLES cycles.
module fault_trigger_scheduler
    import fault_sched_pkg::*;
#(
    parameter int TRIG_COUNT = 4,
    parameter int LAMP_COUNT = 2,
    parameter int DEPTH_W    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  logic_reset,
    input  logic [TRIG_COUNT-1:0] trig_in,
    input  logic [LAMP_COUNT-1:0] lamp_in,
    output logic [LAMP_COUNT-1:0] lamp_out,
    output logic                  fault_out,
    output logic                  busy,
    output logic [DEPTH_W-1:0]    pending_count,
    output logic                  overflow
);

    localparam int POP_W = $clog2(TRIG_COUNT + 1);
    localparam int SUM_W = DEPTH_W + SAT_EXTRA_W;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'({DEPTH_W{1'b1}});

    sched_state_e          state_q, state_d;
    logic [DEPTH_W-1:0]    pending_q, pending_d;
    logic [LAMP_COUNT-1:0] lamp_q, lamp_d;
    logic                  fault_q, fault_d;
    logic                  overflow_q, overflow_d;
    logic [GAP_CNT_W-1:0]  gap_q, gap_d;

    logic [POP_W-1:0]      pop_cnt;
    logic                  dec;
    logic [SUM_W-1:0]      sum_net;
    logic                  sat;
    logic [DEPTH_W-1:0]    pend_next;

    trig_popcount #(
        .WIDTH (TRIG_COUNT),
        .CNT_W (POP_W)
    ) u_popcount (
        .bits_in   (trig_in),
        .count_out (pop_cnt)
    );

    // Net increment is computed one bit wider so saturation is detected from the carry.
    always_comb begin
        dec       = (state_q == ST_FIRE) && (pending_q != '0);
        sum_net   = SUM_W'(pending_q) + SUM_W'(pop_cnt) - SUM_W'(dec);
        sat       = (sum_net > PEND_MAX);
        pend_next = sat ? PEND_MAX[DEPTH_W-1:0] : sum_net[DEPTH_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pend_next;
        lamp_d     = lamp_q;
        fault_d    = 1'b0;
        overflow_d = overflow_q | sat;
        gap_d      = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                lamp_d  = lamp_in;
                fault_d = 1'b1;
                state_d = ST_FIRE;
            end
            ST_FIRE: begin
                gap_d   = GAP_CNT_W'(GAP_CYCLES - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = (pend_next != '0) ? ST_SNAP : ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame clear keeps only the triggers landing in the same cycle; lamp and overflow hold.
        if (logic_reset) begin
            pending_d  = DEPTH_W'(pop_cnt);
            state_d    = ST_IDLE;
            fault_d    = 1'b0;
            gap_d      = '0;
            lamp_d     = lamp_q;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            lamp_q     <= '0;
            fault_q    <= 1'b0;
            overflow_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            lamp_q     <= lamp_d;
            fault_q    <= fault_d;
            overflow_q <= overflow_d;
            gap_q      <= gap_d;
        end
    end

    assign lamp_out      = lamp_q;
    assign fault_out     = fault_q;
    assign pending_count = pending_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_fault_trigger_scheduler.sv
// Table-driven bench for fault_trigger_scheduler with a scoreboard queue of expected outputs.
module tb_fault_trigger_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       logic_reset;
    logic [3:0] trig_in;
    logic [1:0] lamp_in;
    logic [1:0] lamp_out;
    logic       fault_out;
    logic       busy;
    logic [3:0] pending_count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fault_trigger_scheduler #(
        .TRIG_COUNT (4),
        .LAMP_COUNT (2),
        .DEPTH_W    (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .logic_reset   (logic_reset),
        .trig_in       (trig_in),
        .lamp_in       (lamp_in),
        .lamp_out      (lamp_out),
        .fault_out     (fault_out),
        .busy          (busy),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    typedef struct {
        logic       rst;
        logic       lr;
        logic [3:0] trig;
        logic [1:0] lamp;
        logic       fault;
        logic [3:0] pend;
        logic       busy;
        logic [1:0] lamp_o;
        logic       ovf;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];

    function automatic vec_t v(input logic rst, input logic lr, input logic [3:0] trig,
                               input logic [1:0] lamp, input logic fault, input logic [3:0] pend,
                               input logic bsy, input logic [1:0] lamp_o, input logic ovf);
        vec_t r;
        r.rst = rst; r.lr = lr; r.trig = trig; r.lamp = lamp;
        r.fault = fault; r.pend = pend; r.busy = bsy; r.lamp_o = lamp_o; r.ovf = ovf;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    // Issue-drain rows after a FIRE that left `p` pending: GAP p, then SNAP/FIRE/GAP per pending, then IDLE.
    task automatic add_drain(input int p, input logic [1:0] lamp, input logic [1:0] lamp_o, input logic ovf);
        tab.push_back(v(0, 0, 4'b0000, lamp, 0, 4'(p), 1, lamp_o, ovf));
        for (int k = p; k >= 1; k--) begin
            tab.push_back(v(0, 0, 4'b0000, lamp, 0, 4'(k), 1, lamp_o, ovf));
            tab.push_back(v(0, 0, 4'b0000, lamp, 1, 4'(k), 1, lamp_o, ovf));
            tab.push_back(v(0, 0, 4'b0000, lamp, 0, 4'(k - 1), 1, lamp_o, ovf));
        end
        tab.push_back(v(0, 0, 4'b0000, lamp, 0, 4'd0, 0, lamp_o, ovf));
    endtask

    task automatic run_table(input string tag);
        vec_t e;
        for (int i = 0; i < tab.size(); i++) begin
            reset       = tab[i].rst;
            logic_reset = tab[i].lr;
            trig_in     = tab[i].trig;
            lamp_in     = tab[i].lamp;
            sb.push_back(tab[i]);
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check({tag, ".fault"},  i, 32'(fault_out),     32'(e.fault));
            check({tag, ".pend"},   i, 32'(pending_count), 32'(e.pend));
            check({tag, ".busy"},   i, 32'(busy),          32'(e.busy));
            check({tag, ".lamp"},   i, 32'(lamp_out),      32'(e.lamp_o));
            check({tag, ".ovf"},    i, 32'(overflow),      32'(e.ovf));
        end
        tab.delete();
    endtask

    initial begin
        int  pulses;
        bit  done;

        reset = 1'b1; logic_reset = 1'b0; trig_in = '0; lamp_in = '0;

        // Reset, single trigger, 4-trigger burst, then saturation build-up.
        tab.push_back(v(1, 0, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0));
        tab.push_back(v(1, 0, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0));
        tab.push_back(v(0, 0, 4'b0001, 2'b10, 0, 1, 1, 2'b00, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 1, 1, 2'b00, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 1, 1, 1, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 0, 1, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 0, 0, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 0, 0, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b1111, 2'b01, 0, 4, 1, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 0, 4, 1, 2'b10, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 1, 4, 1, 2'b01, 0));
        add_drain(3, 2'b01, 2'b01, 0);
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 0, 4,  1, 2'b01, 0));
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 0, 8,  1, 2'b01, 0));
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 1, 12, 1, 2'b11, 0));
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 0, 15, 1, 2'b11, 0));
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 0, 15, 1, 2'b11, 1));
        run_table("a");

        // Drain the saturated queue with a bounded wait; overflow must survive it.
        trig_in = '0; lamp_in = 2'b00;
        pulses = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (fault_out) pulses++;
            if (!busy) done = 1;
        end
        check("drain_done",   0, 32'(done),          32'd1);
        check("drain_pulses", 0, 32'(pulses),        32'd15);
        check("drain_pend",   0, 32'(pending_count), 32'd0);
        check("drain_ovf",    0, 32'(overflow),      32'd1);

        // Increment coincident with the FIRE exit edge.
        tab.push_back(v(0, 0, 4'b0011, 2'b10, 0, 2, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 2, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 1, 2, 1, 2'b10, 1));
        tab.push_back(v(0, 0, 4'b0011, 2'b10, 0, 3, 1, 2'b10, 1));
        for (int k = 3; k >= 1; k--) begin
            tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 4'(k), 1, 2'b10, 1));
            tab.push_back(v(0, 0, 4'b0000, 2'b10, 1, 4'(k), 1, 2'b10, 1));
            tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 4'(k - 1), 1, 2'b10, 1));
        end
        tab.push_back(v(0, 0, 4'b0000, 2'b10, 0, 0, 0, 2'b10, 1));
        // Frame clear in GAP with 5 pending and a coincident trigger.
        tab.push_back(v(0, 0, 4'b1111, 2'b11, 0, 4, 1, 2'b10, 1));
        tab.push_back(v(0, 0, 4'b0011, 2'b11, 0, 6, 1, 2'b10, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b11, 1, 6, 1, 2'b11, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b11, 0, 5, 1, 2'b11, 1));
        tab.push_back(v(0, 1, 4'b0001, 2'b00, 0, 1, 1, 2'b11, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 1, 1, 2'b11, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 1, 1, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 0, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 1));
        // Frame clear during FIRE: no decrement, only the coincident trigger is kept.
        tab.push_back(v(0, 0, 4'b0001, 2'b01, 0, 1, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 0, 1, 1, 2'b00, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 1, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 1, 4'b0010, 2'b01, 0, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 0, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 1, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 0, 0, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b01, 0, 0, 0, 2'b01, 1));
        // Lamp toggling every cycle: only the SNAP-exit sample may appear.
        tab.push_back(v(0, 0, 4'b0001, 2'b11, 0, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 1, 1, 2'b01, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b11, 1, 1, 1, 2'b11, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 0, 1, 2'b11, 1));
        tab.push_back(v(0, 0, 4'b0000, 2'b11, 0, 0, 0, 2'b11, 1));
        // Full reset beats triggers and clears overflow.
        tab.push_back(v(1, 0, 4'b1111, 2'b11, 0, 0, 0, 2'b00, 0));
        tab.push_back(v(0, 0, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 0));
        run_table("b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
